// File: rtl/pll_reset_sequencer.sv
`timescale 1ns/1ps
// pll_reset_sequencer: PLL areset pulse, lock wait with bounded retries,
// lock qualification and staggered per-domain reset release.
module pll_reset_sequencer #(
  parameter int CLOCKS       = 2,
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 256,
  parameter int STAGGER      = 64,
  parameter int MAX_RETRIES  = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic              restart,
  output logic              pll_areset,
  output logic [CLOCKS-1:0] domain_reset,
  output logic              ready,
  output logic              fault,
  output logic [3:0]        retry_count,
  output logic [7:0]        lock_loss_count
);

  localparam int M0 = (RESET_CYCLES > LOCK_TIMEOUT) ?
                      RESET_CYCLES : LOCK_TIMEOUT;
  localparam int M1 = (LOCK_STABLE > STAGGER) ?
                      LOCK_STABLE : STAGGER;
  localparam int CMAX = (M0 > M1) ? M0 : M1;
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW = (CLOCKS > 1) ? $clog2(CLOCKS) : 1;
  localparam logic [IW-1:0] LAST = IW'(CLOCKS - 1);

  typedef enum logic [2:0] {
    S_ARESET,
    S_WAIT,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [1:0]        sync_q;
  logic              lock_s;
  logic              to_areset;
  logic              areset_q, areset_d;
  logic [CLOCKS-1:0] dr_q, dr_d;
  logic              ready_q, ready_d;
  logic              fault_q, fault_d;
  logic [3:0]        retry_q, retry_d;
  logic [7:0]        llc_q, llc_d;

  assign lock_s = sync_q[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_ARESET;
      cnt_q    <= '0;
      idx_q    <= '0;
      areset_q <= 1'b1;
      dr_q     <= '1;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
      retry_q  <= 4'd0;
      llc_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      areset_q <= areset_d;
      dr_q     <= dr_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
      retry_q  <= retry_d;
      llc_q    <= llc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    areset_d  = areset_q;
    dr_d      = dr_q;
    ready_d   = ready_q;
    fault_d   = fault_q;
    retry_d   = retry_q;
    llc_d     = llc_q;
    to_areset = 1'b0;

    if (restart) begin
      to_areset = 1'b1;
      retry_d   = 4'd0;
      fault_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_ARESET: begin
          if (cnt_q == CW'(RESET_CYCLES - 1)) begin
            state_d  = S_WAIT;
            cnt_d    = '0;
            areset_d = 1'b0;
          end
        end
        S_WAIT: begin
          if (lock_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            if (retry_q == 4'(MAX_RETRIES)) begin
              state_d  = S_FAULT;
              cnt_d    = '0;
              areset_d = 1'b1;
              fault_d  = 1'b1;
            end else begin
              retry_d   = retry_q + 4'd1;
              to_areset = 1'b1;
            end
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
            dr_d[0] = 1'b0;
            cnt_d   = '0;
            idx_d   = IW'(1);
            if (CLOCKS == 1) begin
              state_d = S_RUN;
              ready_d = 1'b1;
              retry_d = 4'd0;
            end else begin
              state_d = S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          // Lock loss outranks a coincident stagger expiry.
          if (!lock_s) begin
            to_areset = 1'b1;
          end else if (cnt_q == CW'(STAGGER - 1)) begin
            dr_d[idx_q] = 1'b0;
            cnt_d       = '0;
            if (idx_q == LAST) begin
              state_d = S_RUN;
              ready_d = 1'b1;
              retry_d = 4'd0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          cnt_d = cnt_q;
          if (!lock_s) begin
            to_areset = 1'b1;
            if (llc_q != 8'hFF) begin
              llc_d = llc_q + 8'd1;
            end
          end
        end
        S_FAULT: begin
          cnt_d = cnt_q;
        end
        default: begin
          to_areset = 1'b1;
        end
      endcase
    end

    if (to_areset) begin
      state_d  = S_ARESET;
      cnt_d    = '0;
      areset_d = 1'b1;
      dr_d     = '1;
      ready_d  = 1'b0;
    end
  end

  assign pll_areset      = areset_q;
  assign domain_reset    = dr_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = llc_q;

endmodule
